// File: rtl/aes_key_sched_mc_if.sv
// Bus bundle for the AES key-schedule engine: expansion request, round-key
// read port and the shared 32-bit S-box lookup.
`timescale 1ns/1ps
interface aes_key_sched_mc_if #(
  parameter int CTX_W = 1
);
  localparam int NUM_CTX = 2**CTX_W;

  logic               init;
  logic [CTX_W-1:0]   init_ctx;
  logic [1:0]         keylen;
  logic [255:0]       key;
  logic [CTX_W-1:0]   rd_ctx;
  logic [3:0]         round;
  logic [127:0]       round_key;
  logic [3:0]         rd_nr;
  logic [NUM_CTX-1:0] ready;
  logic               busy;
  logic               key_err;
  logic [31:0]        sboxw;
  logic [31:0]        new_sboxw;

  // Host / cipher side: issues requests, reads round keys, owns the S-box.
  modport master (
    output init, init_ctx, keylen, key, rd_ctx, round, new_sboxw,
    input  round_key, rd_nr, ready, busy, key_err, sboxw
  );

  // Key-schedule engine side.
  modport slave (
    input  init, init_ctx, keylen, key, rd_ctx, round, new_sboxw,
    output round_key, rd_nr, ready, busy, key_err, sboxw
  );
endinterface

// File: rtl/aes_key_sched_mc.sv
// Word-serial AES-128/192/256 key expansion with NUM_CTX stored schedules.
// One word w[i] is produced per cycle; w[i-1..i-8] live in a small history
// shift register so w[i-Nk] is just a tap selected by Nk.
`timescale 1ns/1ps
module aes_key_sched_mc #(
  parameter int CTX_W = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  aes_key_sched_mc_if.slave bus
);
  localparam int NUM_CTX   = 2**CTX_W;
  localparam int MEM_DEPTH = NUM_CTX * 64;

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  state_t             state_q;
  logic [255:0]       key_q;
  logic [1:0]         keylen_q;
  logic [CTX_W-1:0]   ctx_q;
  logic [5:0]         i_q;
  logic [2:0]         pos_q;
  logic [7:0]         rcon_q;
  logic [31:0]        hist_q [8];
  logic [NUM_CTX-1:0] ready_q;
  logic [3:0]         rd_nr_q [NUM_CTX];
  logic               busy_q;
  logic               key_err_q;

  // Schedule storage: 64 word slots per context, addressed {ctx, word}.
  logic [31:0]        sched_mem [MEM_DEPTH];

  logic [2:0]         nk_m1;
  logic [5:0]         last_idx;
  logic [3:0]         nr;
  logic               is_key;
  logic [2:0]         pos_d;
  logic [7:0]         rcon_d;
  logic [31:0]        temp;
  logic [31:0]        w_old;
  logic [31:0]        w_new;
  logic [31:0]        key_words [8];
  logic [31:0]        rk_word [4];
  logic [5:0]         rk_base;

  genvar gi;

  // Key split into words, MSW first.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_keyw
      assign key_words[gi] = key_q[255-32*gi -: 32];
    end
  endgenerate

  // Per-request geometry derived from the captured key length.
  always_comb begin
    nk_m1    = 3'd3;
    last_idx = 6'd43;
    nr       = 4'd10;
    case (keylen_q)
      2'b01:   begin nk_m1 = 3'd5; last_idx = 6'd51; nr = 4'd12; end
      2'b10:   begin nk_m1 = 3'd7; last_idx = 6'd59; nr = 4'd14; end
      default: begin nk_m1 = 3'd3; last_idx = 6'd43; nr = 4'd10; end
    endcase
  end

  assign temp   = hist_q[0];
  assign w_old  = hist_q[nk_m1];
  assign is_key = (i_q <= {3'b000, nk_m1});
  assign pos_d  = (pos_q == nk_m1) ? 3'd0 : pos_q + 3'd1;
  assign rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  // Next schedule word from the FIPS-197 recurrence.
  always_comb begin
    w_new = w_old ^ temp;
    if (is_key) begin
      w_new = key_words[i_q[2:0]];
    end else if (pos_q == 3'd0) begin
      w_new = w_old ^ {bus.new_sboxw[23:0], bus.new_sboxw[31:24]} ^ {rcon_q, 24'h0};
    end else if ((keylen_q == 2'b10) && (pos_q == 3'd4)) begin
      w_new = w_old ^ bus.new_sboxw;
    end
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      key_q     <= '0;
      keylen_q  <= 2'b00;
      ctx_q     <= '0;
      i_q       <= 6'd0;
      pos_q     <= 3'd0;
      rcon_q    <= 8'h01;
      ready_q   <= '0;
      busy_q    <= 1'b0;
      key_err_q <= 1'b0;
      for (int k = 0; k < 8; k++) hist_q[k] <= 32'h0;
      for (int c = 0; c < NUM_CTX; c++) rd_nr_q[c] <= 4'd0;
    end else begin
      key_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.init) begin
            if (bus.keylen == 2'b11) begin
              key_err_q <= 1'b1;
            end else begin
              key_q                 <= bus.key;
              keylen_q              <= bus.keylen;
              ctx_q                 <= bus.init_ctx;
              ready_q[bus.init_ctx] <= 1'b0;
              busy_q                <= 1'b1;
              i_q                   <= 6'd0;
              pos_q                 <= 3'd0;
              rcon_q                <= 8'h01;
              state_q               <= GEN;
            end
          end
        end
        GEN: begin
          for (int k = 7; k > 0; k--) hist_q[k] <= hist_q[k-1];
          hist_q[0] <= w_new;
          i_q       <= i_q + 6'd1;
          pos_q     <= pos_d;
          if (!is_key && (pos_q == 3'd0)) rcon_q <= rcon_d;
          if (i_q == last_idx) state_q <= DONE;
        end
        DONE: begin
          ready_q[ctx_q] <= 1'b1;
          rd_nr_q[ctx_q] <= nr;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Schedule write port: one word per GEN cycle.
  always_ff @(posedge clk) begin
    if (state_q == GEN) sched_mem[{ctx_q, i_q}] <= w_new;
  end

  // Round-key read: four consecutive words of the selected context.
  assign rk_base = {bus.round, 2'b00};
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rk
      assign rk_word[gi] = sched_mem[{bus.rd_ctx, rk_base + 6'(gi)}];
    end
  endgenerate

  assign bus.round_key = ((bus.round > 4'd14) || (bus.round > rd_nr_q[bus.rd_ctx])) ? 128'h0
                       : {rk_word[0], rk_word[1], rk_word[2], rk_word[3]};
  assign bus.rd_nr     = rd_nr_q[bus.rd_ctx];
  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.key_err   = key_err_q;
  assign bus.sboxw     = (state_q == GEN) ? temp : 32'h0;
endmodule

// File: tb/tb_aes_key_sched_mc.sv
// Bench for aes_key_sched_mc: S-box built from GF(2^8) arithmetic, key
// expansion recomputed with the textbook FIPS-197 loop, and a per-cycle
// compare of every status output, sboxw and round_key against that model.
`timescale 1ns/1ps
module tb_aes_key_sched_mc;
  localparam int CTX_W   = 1;
  localparam int NUM_CTX = 2**CTX_W;

  localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] A2_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] A2_R12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] A3_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A3_R14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic model_on = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [7:0]  sbox [256];
  logic [31:0] exp_w [60];

  aes_key_sched_mc_if #(.CTX_W(CTX_W)) bus ();
  aes_key_sched_mc #(.CTX_W(CTX_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  // External S-box shared with the engine.
  assign bus.new_sboxw = {sbox[bus.sboxw[31:24]], sbox[bus.sboxw[23:16]],
                          sbox[bus.sboxw[15:8]],  sbox[bus.sboxw[7:0]]};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // FIPS-197 KeyExpansion into exp_w.
  task automatic ref_expand(input logic [255:0] k, input int nk);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        exp_w[i] = k[255-32*i -: 32];
      end else begin
        t = exp_w[i-1];
        if (i % nk == 0) begin
          t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xtime(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = subword(t);
        end
        exp_w[i] = exp_w[i-nk] ^ t;
      end
    end
  endtask

  // Behavioural model: request acceptance, completion after W+2 edges.
  logic [31:0]        m_sched [NUM_CTX][60];
  logic [NUM_CTX-1:0] m_ready;
  logic [3:0]         m_nr [NUM_CTX];
  logic               m_busy, m_keyerr;
  int                 m_cnt, m_ctx, m_nk, m_W;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_keyerr = 1'b0; m_cnt = 0; m_ready = '0;
      for (int c = 0; c < NUM_CTX; c++) m_nr[c] = 4'd0;
    end else if (model_on) begin
      m_keyerr = 1'b0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == m_W + 2) begin
          m_ready[m_ctx] = 1'b1;
          m_nr[m_ctx]    = 4'(m_nk + 6);
          m_busy         = 1'b0;
        end
      end else if (bus.init) begin
        if (bus.keylen == 2'b11) begin
          m_keyerr = 1'b1;
        end else begin
          m_ctx = int'(bus.init_ctx);
          m_nk  = 4 + 2 * int'(bus.keylen);
          m_W   = 4 * (m_nk + 7);
          ref_expand(bus.key, m_nk);
          for (int k = 0; k < 60; k++) m_sched[m_ctx][k] = exp_w[k];
          m_ready[m_ctx] = 1'b0;
          m_busy = 1'b1;
          m_cnt  = 1;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    int c, r;
    if (reset_n && model_on) begin
      c = int'(bus.rd_ctx);
      r = int'(bus.round);
      check("busy", bus.busy, m_busy);
      check("ready", bus.ready, m_ready);
      check("key_err", bus.key_err, m_keyerr);
      check("rd_nr", bus.rd_nr, m_nr[c]);
      if (m_busy && m_cnt >= 2 && m_cnt <= m_W)
        check("sboxw", bus.sboxw, m_sched[m_ctx][m_cnt-2]);
      else if (!(m_busy && m_cnt == 1))
        check("sboxw_idle", bus.sboxw, 32'h0);
      if (!(m_busy && m_ctx == c)) begin
        if (r > 14 || r > int'(m_nr[c]))
          check("round_key_zero", bus.round_key, 128'h0);
        else if (m_ready[c])
          check("round_key", bus.round_key,
                {m_sched[c][4*r], m_sched[c][4*r+1], m_sched[c][4*r+2], m_sched[c][4*r+3]});
      end
    end
  end

  task automatic rand_reads();
    bus.rd_ctx = CTX_W'($urandom_range(0, NUM_CTX - 1));
    bus.round  = 4'($urandom_range(0, 15));
  endtask

  // mode 0: random reads; 1: hold rd_ctx0/round10 and pin A.1; 2: pulse init while busy.
  task automatic expand_run(input int c, input logic [1:0] kl, input logic [255:0] k, input int mode);
    int edges = -1;
    int w_exp = 4 * (4 + 2 * int'(kl) + 7) + 2;
    bus.init = 1'b1; bus.init_ctx = CTX_W'(c); bus.keylen = kl; bus.key = k;
    if (mode == 1) begin bus.rd_ctx = '0; bus.round = 4'd10; end
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (n == 1) bus.init = 1'b0;
      if (mode == 2 && n == 10) begin bus.init = 1'b1; bus.init_ctx = ~CTX_W'(c); end
      if (mode == 2 && n == 11) bus.init = 1'b0;
      if (mode == 1) check("agility_r10", bus.round_key, A1_R10);
      else rand_reads();
      if (bus.ready[c]) begin edges = n; break; end
    end
    check("done_edges", edges, w_exp);
    $display("[TB] expansion ctx=%0d keylen=%0d done after %0d edges", c, kl, edges);
  endtask

  task automatic rand_key(output logic [255:0] k);
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
  endtask

  initial begin
    logic [255:0] rk;
    bus.init = 1'b0; bus.init_ctx = '0; bus.keylen = 2'b00; bus.key = '0;
    bus.rd_ctx = '0; bus.round = 4'd0;

    build_sbox();
    check("sbox_00", sbox[0], 8'h63);
    check("sbox_53", sbox[8'h53], 8'hed);
    ref_expand({A1_KEY, 128'h0}, 4);
    check("model_a1_r10", {exp_w[40], exp_w[41], exp_w[42], exp_w[43]}, A1_R10);
    ref_expand({A2_KEY, 64'h0}, 6);
    check("model_a2_r12", {exp_w[48], exp_w[49], exp_w[50], exp_w[51]}, A2_R12);
    ref_expand(A3_KEY, 8);
    check("model_a3_r14", {exp_w[56], exp_w[57], exp_w[58], exp_w[59]}, A3_R14);

    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ready", bus.ready, '0);
    check("rst_key_err", bus.key_err, 1'b0);
    check("rst_rd_nr", bus.rd_nr, 4'd0);
    #12 reset_n = 1'b1;
    model_on = 1'b1;
    @(posedge clk); #1;

    // A.1 into ctx0
    expand_run(0, 2'b00, {A1_KEY, 128'h0}, 0);
    bus.rd_ctx = '0; bus.round = 4'd0; #1;
    check("a1_r0", bus.round_key, A1_KEY);
    bus.round = 4'd10; #1;
    check("a1_r10", bus.round_key, A1_R10);
    check("a1_nr", bus.rd_nr, 4'd10);

    // A.2 into ctx1 with a stray init while busy
    @(posedge clk); #1;
    expand_run(1, 2'b01, {A2_KEY, 64'h0}, 2);
    bus.rd_ctx = 1'b1; bus.round = 4'd12; #1;
    check("a2_r12", bus.round_key, A2_R12);
    bus.round = 4'd13; #1;
    check("a2_r13_zero", bus.round_key, 128'h0);
    check("a2_nr", bus.rd_nr, 4'd12);

    // reserved key length
    @(posedge clk); #1;
    bus.init = 1'b1; bus.keylen = 2'b11; bus.init_ctx = '0;
    @(posedge clk); #1;
    bus.init = 1'b0;
    check("kerr_pulse", bus.key_err, 1'b1);
    check("kerr_busy", bus.busy, 1'b0);
    check("kerr_ready", bus.ready, 2'b11);
    @(posedge clk); #1;
    check("kerr_clear", bus.key_err, 1'b0);

    // A.3 into ctx1 while ctx0 is read every cycle
    expand_run(1, 2'b10, A3_KEY, 1);
    bus.rd_ctx = 1'b1; bus.round = 4'd14; #1;
    check("a3_r14", bus.round_key, A3_R14);
    check("a3_nr", bus.rd_nr, 4'd14);

    // abort mid-expansion with reset_n
    @(posedge clk); #1;
    bus.init = 1'b1; bus.init_ctx = '0; bus.keylen = 2'b00; bus.key = {A1_KEY, 128'h0};
    for (int n = 1; n <= 21; n++) begin
      @(posedge clk); #1;
      if (n == 1) bus.init = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_ready", bus.ready, '0);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    expand_run(0, 2'b00, {A1_KEY, 128'h0}, 0);
    bus.rd_ctx = '0; bus.round = 4'd10; #1;
    check("reinit_a1_r10", bus.round_key, A1_R10);

    // back-to-back: init held high with randomly changing requests
    @(posedge clk); #1;
    rand_key(rk);
    bus.init = 1'b1; bus.key = rk; bus.keylen = 2'($urandom_range(0, 2));
    bus.init_ctx = CTX_W'($urandom_range(0, NUM_CTX - 1));
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      rand_reads();
      if ($urandom_range(0, 15) == 0) begin
        rand_key(rk);
        bus.key = rk;
        bus.keylen = 2'($urandom_range(0, 3));
        bus.init_ctx = CTX_W'($urandom_range(0, NUM_CTX - 1));
      end
    end
    bus.init = 1'b0;
    for (int n = 0; n < 70; n++) begin
      @(posedge clk); #1;
      rand_reads();
    end

    // random keys of each length
    for (int j = 0; j < 6; j++) begin
      rand_key(rk);
      expand_run(j % NUM_CTX, 2'(j % 3), rk, 0);
      @(posedge clk); #1;
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aes_key_sched_mc.md
Name: aes_key_sched_mc

Overview:
- Word-serial AES key expansion engine supporting 128-, 192- and 256-bit keys.
- Stores expanded schedules for NUM_CTX independent key contexts.
- The cipher datapath can read round keys from any ready context while another context is being expanded (key agility).
- Shares an external 32-bit S-box with the cipher core through a sboxw/new_sboxw pair.

Parameters:
CTX_W, 1, context index width; NUM_CTX = 2**CTX_W contexts.
NUM_CTX, 2**CTX_W, derived (localparam), number of stored schedules.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
init  in  1  start expansion request (level, sampled in IDLE only)
init_ctx  in  CTX_W  target context for init
keylen  in  2  00=128, 01=192, 10=256, 11=reserved
key  in  256  key, MSB-aligned: 128 uses [255:128], 192 uses [255:64], 256 uses all
rd_ctx  in  CTX_W  context selected for round-key read
round  in  4  round index 0..14
round_key  out  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]} of rd_ctx; combinational read
rd_nr  out  4  stored Nr of rd_ctx (10/12/14; 0 if never expanded)
ready  out  NUM_CTX  per-context schedule-valid flags
busy  out  1  expansion in progress
key_err  out  1  one-cycle pulse: init with keylen=11 rejected
sboxw  out  32  word to substitute (w[i-1], unrotated)
new_sboxw  in  32  SubWord(sboxw), combinational same cycle

Behaviour:
- Reset (async, reset_n low): state IDLE, ready=0, busy=0, key_err=0, rd_nr per context=0, rcon=0x01, word counter=0. Schedule memory is not reset; round_key is don't-care for non-ready contexts.
- Derived per request: Nk=4/6/8, Nr=10/12/14, W=4*(Nr+1)=44/52/60 words.
- States:
  - IDLE: on init with legal keylen, capture key, keylen and ctx; clear ready[ctx]; set busy; set i=0, pos=0, rcon=0x01; go to GEN.
  - IDLE, init with keylen=11: stay in IDLE, pulse key_err next cycle, no state change.
  - GEN: write one word w[i] per cycle into memory[ctx][i]. Go to DONE on the cycle that writes i=W-1.
  - DONE: set ready[ctx]; latch rd_nr[ctx]=Nr; clear busy; go to IDLE.
- Word rule, with temp=w[i-1] taken from an internal 8-word history shift register:
  - i<Nk: w[i] = key word i, MSW first.
  - pos==0: w[i] = w[i-Nk] ^ RotWord(new_sboxw) ^ {rcon,24'h0}; then advance rcon = xtime(rcon) (0x80 -> 0x1b).
  - Nk==8 and pos==4: w[i] = w[i-Nk] ^ new_sboxw.
  - otherwise: w[i] = w[i-Nk] ^ temp.
  - pos counts modulo Nk with wrap; no divider.
- sboxw = temp in GEN, 0 otherwise.
- Timing: with the init sampling edge as edge 1, words are written at edges 2..W+1 and ready[ctx] rises after edge W+2 (46/54/62 edges), same edge busy falls.
- init while busy (GEN/DONE): ignored, no error.
- A new init to an already-ready context: ready clears after edge 1 and the schedule is overwritten.
- Reads of other ready contexts stay valid throughout. Reads of the context being expanded are don't-care.
- round > rd_nr or round > 14: round_key = 0.
- reset_n asserted mid-GEN: immediate abort; all ready=0; the partial schedule is invalid.

Test Plan:
- 128-bit FIPS-197 A.1 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, ctx0 -> ready[0] after 46 edges; round 0 = key; round 10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6; rd_nr=10.
- 192-bit A.2 key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, ctx1 -> ready[1] after 54 edges; round 12 = e98ba06f_448c773c_8ecc7204_01002202; round 13 = 0.
- 256-bit A.3 key 603deb10…0914dff4 into ctx1 while ctx0 holds the A.1 schedule -> every cycle of expansion, rd_ctx=0 round 10 still reads d014f9a8…; ctx1 round 14 = fe4890d1_e6188d0b_046df344_706c631e after 62 edges.
- keylen=11 with init in IDLE -> key_err high exactly one cycle; busy stays 0; ready unchanged. init pulsed while busy -> ignored, completion timing unchanged.
- reset_n low at GEN word 20 -> busy=0 and ready=0 asynchronously. Re-init after release -> correct A.1 schedule.
- Back-to-back: init held high continuously -> re-expansion starts on the edge after DONE (IDLE sampling); the sboxw sequence matches the reference model.
